// File: rtl/rgb_pwm_array.sv
// Multi-channel PWM engine for RGB LED segments.
// One shared prescaled period counter, per-channel target/active duty registers,
// duty changes take effect only at period boundaries, run/stop control FSM.
// Optional build macro RGB_PWM_FADE_EN: active duty steps by one toward target per period
// instead of jumping, and restarts from dark after each stop.
module rgb_pwm_array #(
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned AW       = 3
) (
  input  logic                Clock_in,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic                Duty_wr_en,
  input  logic [AW-1:0]       Duty_wr_addr,
  input  logic [WIDTH-1:0]    Duty_wr_data,
  output logic [CHANNELS-1:0] Pwm_out,
  output logic                Period_start,
  output logic                Busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] target     [CHANNELS];
  logic [WIDTH-1:0] active     [CHANNELS];
  logic [WIDTH-1:0] target_fwd [CHANNELS];
  logic             tick_c;
  logic             boundary_c;
  logic             start_c;
  logic             wr_ok_c;

  assign tick_c     = (state != IDLE) && (presc == PRE_MAX);
  assign boundary_c = tick_c && (cnt == CNT_MAX);
  assign start_c    = (state == IDLE) && Enable;
  assign wr_ok_c    = Duty_wr_en && (32'(Duty_wr_addr) < CHANNELS);

  // Target as seen this cycle, forwarding a same-cycle write so a boundary load never misses it
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      target_fwd[i] = target[i];
      if (wr_ok_c && (Duty_wr_addr == AW'(i))) target_fwd[i] = Duty_wr_data;
    end
  end

  // Control FSM next state: stop request only takes effect at the end of a period
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (Enable) state_next = RUN;
      RUN:      if (!Enable) state_next = STOPPING;
      STOPPING: begin
        if (Enable)          state_next = RUN;
        else if (boundary_c) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Prescaler and period counter, both parked at zero while idle
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick_c) begin
      presc <= '0;
      cnt   <= cnt + WIDTH'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Target duty registers, writable in any state
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CHANNELS; i++) target[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) target[i] <= target_fwd[i];
    end
  end

  // Active (shadow) duty, only changed at period boundaries or on start
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < CHANNELS; i++) active[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef RGB_PWM_FADE_EN
        if (boundary_c) begin
          if (state_next == IDLE)             active[i] <= '0;
          else if (active[i] < target_fwd[i]) active[i] <= active[i] + WIDTH'(1);
          else if (active[i] > target_fwd[i]) active[i] <= active[i] - WIDTH'(1);
        end
`else
        if (start_c || boundary_c) active[i] <= target_fwd[i];
`endif
      end
    end
  end

  // Registered outputs: PWM compare, period pulse, busy flag
  always_ff @(posedge Clock_in or negedge Reset_n) begin
    if (!Reset_n) begin
      Pwm_out      <= '0;
      Period_start <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) Pwm_out[i] <= (state != IDLE) && (cnt < active[i]);
      Period_start <= start_c || (boundary_c && (state_next != IDLE));
      Busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_array.sv
// Testbench for rgb_pwm_array: directed period-by-period sequence with randomized duties,
// checked against a per-period duty model (handles the RGB_PWM_FADE_EN build as well).
module tb_rgb_pwm_array;

  localparam int unsigned CH  = 6;
  localparam int unsigned W   = 8;
  localparam int unsigned AW  = 3;
  localparam int          PER = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          en3;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] pwm;
  logic [CH-1:0] pwm3;
  logic          ps;
  logic          ps3;
  logic          busy;
  logic          busy3;

  int tests = 0;
  int fails = 0;
  int tgt [CH];
  int act [CH];
  int hi  [CH];
  int busy_lo;
  int ps_extra;

  always #5 clk = ~clk;

  rgb_pwm_array #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1), .AW(AW)) dut (
    .Clock_in(clk), .Reset_n(rst_n), .Enable(enable),
    .Duty_wr_en(wr_en), .Duty_wr_addr(wr_addr), .Duty_wr_data(wr_data),
    .Pwm_out(pwm), .Period_start(ps), .Busy(busy)
  );

  rgb_pwm_array #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(3), .AW(AW)) dut3 (
    .Clock_in(clk), .Reset_n(rst_n), .Enable(en3),
    .Duty_wr_en(wr_en), .Duty_wr_addr(wr_addr), .Duty_wr_data(wr_data),
    .Pwm_out(pwm3), .Period_start(ps3), .Busy(busy3)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Duty used by the next period, from the target values in force at the boundary
  task automatic model_boundary(input bit to_idle);
    for (int i = 0; i < CH; i++) begin
`ifdef RGB_PWM_FADE_EN
      if (to_idle)            act[i] = 0;
      else if (act[i] < tgt[i]) act[i] = act[i] + 1;
      else if (act[i] > tgt[i]) act[i] = act[i] - 1;
`else
      act[i] = tgt[i];
`endif
    end
  endtask

  task automatic model_start();
`ifndef RGB_PWM_FADE_EN
    for (int i = 0; i < CH; i++) act[i] = tgt[i];
`endif
  endtask

  task automatic write_idle(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = W'(d);
    @(negedge clk);
    wr_en = 1'b0;
    if (a < CH) tgt[a] = d;
  endtask

  // One period from cnt 0 to cnt 255, optional write and enable changes at given cnt values
  task automatic run_window(input int wr_cyc, input int wr_a, input int wr_d,
                            input int off_cyc, input int on_cyc);
    for (int i = 0; i < CH; i++) hi[i] = 0;
    busy_lo = 0; ps_extra = 0;
    for (int k = 0; k < PER; k++) begin
      for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
      if (!busy) busy_lo++;
      if (k > 0 && ps) ps_extra++;
      wr_en = (k == wr_cyc);
      wr_addr = AW'(wr_a); wr_data = W'(wr_d);
      if (k == off_cyc) enable = 1'b0;
      if (k == on_cyc)  enable = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    if (wr_cyc >= 0 && wr_a < CH) tgt[wr_a] = wr_d;
  endtask

  task automatic check_window(input string tag, input bit stopping);
    for (int i = 0; i < CH; i++) check($sformatf("%s_hi_ch%0d", tag, i), hi[i], act[i]);
    check({tag, "_busy_low"}, busy_lo, 0);
    check({tag, "_ps_extra"}, ps_extra, 0);
    if (!stopping) begin
      check({tag, "_ps_wrap"}, int'(ps), 1);
      model_boundary(1'b0);
    end else begin
      check({tag, "_stop_busy"}, int'(busy), 0);
      check({tag, "_stop_pwm"}, int'(pwm), 0);
      check({tag, "_stop_ps"}, int'(ps), 0);
      model_boundary(1'b1);
    end
  endtask

  initial begin
    int hi3 [CH];
    int ps3_extra;
    rst_n = 1'b0; enable = 1'b0; en3 = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < CH; i++) begin tgt[i] = 0; act[i] = 0; end

    #23;
    check("rst_pwm", int'(pwm), 0);
    check("rst_ps", int'(ps), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic duties incl. the 0 and full-scale extremes, then out-of-range addresses
    write_idle(0, 64);
    write_idle(1, 0);
    write_idle(2, 255);
    for (int i = 3; i < CH; i++) write_idle(i, int'($urandom_range(0, 255)));
    write_idle(6, int'($urandom_range(1, 255)));
    write_idle(7, int'($urandom_range(1, 255)));
    check("idle_busy", int'(busy), 0);

    enable = 1'b1;
    @(negedge clk);
    model_start();
    check("start_ps", int'(ps), 1);
    check("start_busy", int'(busy), 1);

    run_window(-1, 0, 0, -1, -1);
    check_window("w1", 1'b0);
    // Write landing on the boundary cycle must be used by the next period
    run_window(255, 2, 128, -1, -1);
    check_window("w2_bndwr", 1'b0);
    // Mid-period write must not disturb the running period
    run_window(50, 2, 32, -1, -1);
    check_window("w3_midwr", 1'b0);
    run_window(-1, 0, 0, -1, -1);
    check_window("w4", 1'b0);

    for (int r = 0; r < 5; r++) begin
      run_window(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)), -1, -1);
      check_window($sformatf("rnd%0d", r), 1'b0);
    end

    // Stop request mid-period: period completes, then idle
    run_window(-1, 0, 0, 100, -1);
    check_window("stop", 1'b1);
    repeat (5) @(negedge clk);
    check("idle_hold_pwm", int'(pwm), 0);
    check("idle_hold_busy", int'(busy), 0);

    enable = 1'b1;
    @(negedge clk);
    model_start();
    check("restart_ps", int'(ps), 1);
    run_window(-1, 0, 0, -1, -1);
    check_window("w_restart", 1'b0);
    // Stop then re-enable inside the same period: no gap
    run_window(10, 0, 200, 100, 200);
    check_window("reen", 1'b0);

    // Asynchronous reset in the middle of a pulse
    repeat (120) @(negedge clk);
    check("pre_rst_pwm0", int'(pwm[0]), (119 < act[0]) ? 1 : 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ps", int'(ps), 0);
    enable = 1'b0;
    for (int i = 0; i < CH; i++) begin tgt[i] = 0; act[i] = 0; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp scenario from idle: only ch0 set, all other targets must read back as 0
    write_idle(0, 4);
    enable = 1'b1;
    @(negedge clk);
    model_start();
    check("ramp_start_ps", int'(ps), 1);
    for (int p = 0; p < 5; p++) begin
      run_window(-1, 0, 0, -1, -1);
      check_window($sformatf("ramp%0d", p), 1'b0);
    end
    run_window(int'($urandom_range(0, 255)), 0, 2, -1, -1);
    check_window("ramp5", 1'b0);
    for (int p = 6; p < 8; p++) begin
      run_window(-1, 0, 0, -1, -1);
      check_window($sformatf("ramp%0d", p), 1'b0);
    end

    // Prescaled instance: period of 3*256 clocks, high time scaled by 3
    en3 = 1'b1;
    @(negedge clk);
    check("p3_start_ps", int'(ps3), 1);
    for (int i = 0; i < CH; i++) hi3[i] = 0;
    ps3_extra = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      for (int i = 0; i < CH; i++) hi3[i] += int'(pwm3[i]);
      if (k > 0 && ps3) ps3_extra++;
      @(negedge clk);
    end
    check("p3_ps_extra", ps3_extra, 0);
    check("p3_ps_wrap", int'(ps3), 1);
    check("p3_busy", int'(busy3), 1);
    for (int i = 0; i < CH; i++) begin
`ifdef RGB_PWM_FADE_EN
      check($sformatf("p3_hi_ch%0d", i), hi3[i], 0);
`else
      check($sformatf("p3_hi_ch%0d", i), hi3[i], 3 * tgt[i]);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
